bcd_updown_counter: RTL



---
 rtl/bcd_updown_counter_pkg.sv | 19 +
 rtl/bcd_updown_counter_digit.sv | 61 ++++++
 rtl/bcd_updown_counter.sv | 102 ++++++++++
 3 files changed

// File: rtl/bcd_updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and helpers for the BCD up/down counter.
//   DIGIT_W   : width of one BCD digit
//   DIGIT_MAX : largest legal BCD digit value
//   DIGIT_MIN : smallest legal BCD digit value
//   bcd_valid : 1 when a 4-bit value is a legal BCD digit (0..9)
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] DIGIT_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [3:0] v);
        return (v <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decimal digit of the up/down counter.
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset, clears the digit
//   CLR    : synchronous clear (highest priority)
//   LOAD   : synchronous load of din (illegal values load as 0)
//   din    : digit load value
//   ci     : count-in; the digit steps when ci=1 and no CLR/LOAD
//   UP     : direction, 1 = increment, 0 = decrement
//   q      : current digit value, always 0..9
//   co     : terminal count (9 going up, 0 going down) gated by ci
//   err_ld : LOAD is active and din is not a legal digit
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [3:0] din,
    input  logic       ci,
    input  logic       UP,
    output logic [3:0] q,
    output logic       co,
    output logic       err_ld
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (CLR) begin
            q_d = DIGIT_MIN;
        end else if (LOAD) begin
            q_d = bcd_valid(din) ? din : DIGIT_MIN;
        end else if (ci) begin
            if (UP) begin
                // >= rather than == so an illegal value can never persist
                q_d = (q_q >= DIGIT_MAX) ? DIGIT_MIN : q_q + 4'd1;
            end else begin
                q_d = (q_q == DIGIT_MIN) ? DIGIT_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= DIGIT_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign co     = ci & (UP ? (q_q == DIGIT_MAX) : (q_q == DIGIT_MIN));
    assign err_ld = LOAD & ~bcd_valid(din);

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// Multi-digit BCD up/down counter feeding BCD-to-7-segment decoders.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   CLR  : synchronous clear of Q and ERR (priority over LOAD and EN)
//   LOAD : synchronous parallel load from D (priority over EN)
//   EN   : count enable
//   UP   : 1 = increment, 0 = decrement
//   D    : packed BCD load value, digit i at D[4i+3:4i]
//   Q    : packed BCD count
//   RBI  : per-digit ripple-blank-in; 0 means the digit may be blanked if zero
//   CO   : one-cycle carry pulse, high alongside the wrapped all-zeros value
//   BO   : one-cycle borrow pulse, high alongside the wrapped all-nines value
//   ERR  : sticky, set by loading an illegal digit, cleared by CLR/RST
// -----------------------------------------------------------------------------
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic                  EN,
    input  logic                  UP,
    input  logic [4*NDIG-1:0]     D,
    output logic [4*NDIG-1:0]     Q,
    output logic [NDIG-1:0]       RBI,
    output logic                  CO,
    output logic                  BO,
    output logic                  ERR
);

    // carry[i] is the count-in of digit i; carry[NDIG] means every digit is
    // at its terminal value and EN is high, i.e. the whole counter wraps.
    logic [NDIG:0]   carry;
    logic [NDIG-1:0] err_ld;

    logic co_q, co_d;
    logic bo_q, bo_d;
    logic err_q, err_d;

    assign carry[0] = EN;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .CLK    (CLK),
            .RST    (RST),
            .CLR    (CLR),
            .LOAD   (LOAD),
            .din    (D[DIGIT_W*g +: DIGIT_W]),
            .ci     (carry[g]),
            .UP     (UP),
            .q      (Q[DIGIT_W*g +: DIGIT_W]),
            .co     (carry[g+1]),
            .err_ld (err_ld[g])
        );
    end

    always_comb begin
        co_d  = 1'b0;
        bo_d  = 1'b0;
        err_d = err_q;
        if (CLR) begin
            err_d = 1'b0;
        end else if (LOAD) begin
            err_d = err_q | (|err_ld);
        end else begin
            co_d = carry[NDIG] & UP;
            bo_d = carry[NDIG] & ~UP;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            co_q  <= 1'b0;
            bo_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            co_q  <= co_d;
            bo_q  <= bo_d;
            err_q <= err_d;
        end
    end

    assign CO  = co_q;
    assign BO  = bo_q;
    assign ERR = err_q;

    // A digit may be blanked only while every digit above it is zero. The
    // least significant digit is never blanked so zero still shows "0".
    always_comb begin
        RBI = '0;
        for (int i = NDIG - 2; i >= 0; i--) begin
            RBI[i] = RBI[i+1] | (Q[DIGIT_W*(i+1) +: DIGIT_W] != DIGIT_MIN);
        end
        RBI[0] = 1'b1;
    end

endmodule
